pcileech_tx_arbiter: RTL and testbench

Parametrised N-channel, packet-aware arbiter that merges 64-bit tagged words from N source FIFOs into the single 64→32 FT601 TX FIFO. It generalises the fixed four-source priority mux with three additions:
- selectable fixed-priority or round-robin arbitration;
- a per-packet grant lock, so a multi-word TLP is never interleaved with other traffic;
- a lock watchdog and MAGIC filtering.

It sits in the `CLK` domain between the per-source TX FIFOs and the `fifo_64_32` write port.

---
 rtl/pcileech_tx_arbiter_if.sv | 26 ++
 rtl/pcileech_tx_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_pcileech_tx_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_tx_arbiter_if.sv
// Handshake bundle between the per-source TX FIFOs, the TX arbiter and the FT601 TX FIFO write port.
// The arbiter connects through the master modport; the surrounding sources and sink use slave.
interface pcileech_tx_arbiter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH*64-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_last;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 tx_almost_full;
    logic [63:0]          tx_data;
    logic                 tx_wren;
    logic                 drop_pulse;
    logic                 timeout_pulse;
    logic [NUM_CH*16-1:0] stat_words;

    modport master (
        input  ch_data, ch_valid, ch_last, tx_almost_full,
        output ch_ready, tx_data, tx_wren, drop_pulse, timeout_pulse, stat_words
    );

    modport slave (
        output ch_data, ch_valid, ch_last, tx_almost_full,
        input  ch_ready, tx_data, tx_wren, drop_pulse, timeout_pulse, stat_words
    );
endinterface

// File: rtl/pcileech_tx_arbiter.sv
// Packet-aware N-channel arbiter merging MAGIC-tagged 64-bit words into the FT601 TX FIFO.
// Define PCILEECH_TX_ARB_STATS_EN to build saturating per-channel forwarded-word counters.
module pcileech_tx_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int ARB_RR       = 0,
    parameter int LOCK_TIMEOUT = 1023
) (
    input  logic                  CLK,
    input  logic                  RESET,
    pcileech_tx_arbiter_if.master bus
);
    localparam int               IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [15:0]      WD_LIMIT = 16'(LOCK_TIMEOUT);
    localparam logic [7:0]       MAGIC    = 8'h77;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r, state_next_s;
    logic [IDX_W-1:0] lock_idx_r, lock_idx_next_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_next_s;
    logic [15:0]      wd_r, wd_next_s;
    logic [IDX_W-1:0] start_s, win_idx_s, grant_idx_s;
    logic             win_found_s, grant_req_s, grant_en_s;
    logic [63:0]      grant_data_s;
    logic             grant_last_s, magic_ok_s, fwd_s, drop_s, timeout_s;
    logic [NUM_CH-1:0] ready_s;
    logic [63:0]      tx_data_r;
    logic             tx_wren_r, drop_pulse_r, timeout_pulse_r;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            return '0;
        end else begin
            return idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign start_s = (ARB_RR != 0) ? rr_ptr_r : '0;

    // Idle-state winner: first valid channel scanning upward from start_s with wrap.
    always_comb begin
        logic [IDX_W:0] cand;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, start_s} + (IDX_W+1)'(k);
            if (cand >= NUM_CH_W) begin
                cand = cand - NUM_CH_W;
            end else begin
                cand = cand;
            end
            if (!win_found_s && bus.ch_valid[cand[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant source: fresh arbitration when idle, only the held channel while locked.
    always_comb begin
        grant_idx_s = win_idx_s;
        grant_req_s = win_found_s;
        if (state_r == ST_LOCKED) begin
            grant_idx_s = lock_idx_r;
            grant_req_s = bus.ch_valid[lock_idx_r];
        end else begin
            grant_idx_s = win_idx_s;
            grant_req_s = win_found_s;
        end
    end

    assign grant_en_s   = grant_req_s & ~RESET & ~bus.tx_almost_full;
    assign grant_data_s = bus.ch_data[{grant_idx_s, 6'd0} +: 64];
    assign grant_last_s = bus.ch_last[grant_idx_s];
    assign magic_ok_s   = (grant_data_s[7:0] == MAGIC);
    assign fwd_s        = grant_en_s & magic_ok_s;
    assign drop_s       = grant_en_s & ~magic_ok_s;

    // One-hot ready toward the granted channel only.
    always_comb begin
        ready_s = '0;
        if (grant_en_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Lock FSM with watchdog; a transfer in the expiry cycle clears the watchdog, so it wins.
    always_comb begin
        state_next_s    = state_r;
        lock_idx_next_s = lock_idx_r;
        rr_ptr_next_s   = rr_ptr_r;
        wd_next_s       = wd_r;
        timeout_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wd_next_s = 16'd0;
                if (grant_en_s && !grant_last_s) begin
                    state_next_s    = ST_LOCKED;
                    lock_idx_next_s = grant_idx_s;
                end else if (grant_en_s) begin
                    rr_ptr_next_s = next_idx(grant_idx_s);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (grant_en_s) begin
                    wd_next_s = 16'd0;
                    if (grant_last_s) begin
                        state_next_s  = ST_IDLE;
                        rr_ptr_next_s = next_idx(lock_idx_r);
                    end else begin
                        state_next_s = ST_LOCKED;
                    end
                end else if ((wd_r + 16'd1) == WD_LIMIT) begin
                    state_next_s  = ST_IDLE;
                    rr_ptr_next_s = next_idx(lock_idx_r);
                    wd_next_s     = 16'd0;
                    timeout_s     = 1'b1;
                end else begin
                    wd_next_s = wd_r + 16'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                wd_next_s    = 16'd0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            lock_idx_r <= '0;
            rr_ptr_r   <= '0;
            wd_r       <= 16'd0;
        end else begin
            state_r    <= state_next_s;
            lock_idx_r <= lock_idx_next_s;
            rr_ptr_r   <= rr_ptr_next_s;
            wd_r       <= wd_next_s;
        end
    end

    // Registered downstream write port and status pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_data_r       <= 64'd0;
            tx_wren_r       <= 1'b0;
            drop_pulse_r    <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            tx_wren_r       <= fwd_s;
            drop_pulse_r    <= drop_s;
            timeout_pulse_r <= timeout_s;
            if (fwd_s) begin
                tx_data_r <= grant_data_s;
            end
        end
    end

    assign bus.ch_ready      = ready_s;
    assign bus.tx_data       = tx_data_r;
    assign bus.tx_wren       = tx_wren_r;
    assign bus.drop_pulse    = drop_pulse_r;
    assign bus.timeout_pulse = timeout_pulse_r;

`ifdef PCILEECH_TX_ARB_STATS_EN
    logic [15:0]          stat_r [NUM_CH];
    logic [NUM_CH*16-1:0] stat_flat_s;

    // Saturating count of words actually written downstream, per channel.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_r[i] <= 16'd0;
            end
        end else if (fwd_s && (stat_r[grant_idx_s] != 16'hFFFF)) begin
            stat_r[grant_idx_s] <= stat_r[grant_idx_s] + 16'd1;
        end
    end

    // Flatten counters onto the status bus.
    always_comb begin
        stat_flat_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            stat_flat_s[16*i +: 16] = stat_r[i];
        end
    end

    assign bus.stat_words = stat_flat_s;
`else
    assign bus.stat_words = '0;
`endif

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// Directed self-checking bench: fixed-priority/lock/MAGIC/watchdog on one instance, round-robin on a second.
module tb_pcileech_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcileech_tx_arbiter_if #(.NUM_CH(4)) bus_fp ();
    pcileech_tx_arbiter_if #(.NUM_CH(4)) bus_rr ();

    pcileech_tx_arbiter #(.NUM_CH(4), .ARB_RR(0), .LOCK_TIMEOUT(8)) dut_fp (
        .CLK(clk), .RESET(rst), .bus(bus_fp)
    );
    pcileech_tx_arbiter #(.NUM_CH(4), .ARB_RR(1), .LOCK_TIMEOUT(8)) dut_rr (
        .CLK(clk), .RESET(rst), .bus(bus_rr)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [64:0] srcq [4][$];
    logic [3:0]  take_s   = 4'b0000;
    logic [63:0] outq[$];
    int          out_cyc[$];
    int          drop_cyc[$];
    int          to_cyc[$];
    logic [63:0] rr_outq[$];
    int          rr_cyc[$];

    function automatic logic [63:0] mkw(input int ch, input int n);
        return {8'(ch), 40'h0, 8'(n), 8'h77};
    endfunction
    function automatic logic [63:0] out_at(input int i);
        return (i < outq.size()) ? outq[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction
    function automatic int cyc_at(input int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -1000;
    endfunction
    function automatic int drop_at(input int i);
        return (i < drop_cyc.size()) ? drop_cyc[i] : -2000;
    endfunction
    function automatic int to_at(input int i);
        return (i < to_cyc.size()) ? to_cyc[i] : -3000;
    endfunction
    function automatic logic [63:0] rr_at(input int i);
        return (i < rr_outq.size()) ? rr_outq[i] : 64'hBAD1_BAD1_BAD1_BAD1;
    endfunction
    function automatic int rr_cyc_at(input int i);
        return (i < rr_cyc.size()) ? rr_cyc[i] : -4000;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_obs();
        outq.delete();
        out_cyc.delete();
        drop_cyc.delete();
        to_cyc.delete();
    endtask

    // Source FIFO model: remember consumption before the edge, pop and re-present after it.
    always @(negedge clk) take_s <= bus_fp.ch_valid & bus_fp.ch_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (take_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0) begin
                bus_fp.ch_valid[i]         = 1'b1;
                bus_fp.ch_last[i]          = srcq[i][0][64];
                bus_fp.ch_data[64*i +: 64] = srcq[i][0][63:0];
            end else begin
                bus_fp.ch_valid[i]         = 1'b0;
                bus_fp.ch_last[i]          = 1'b0;
                bus_fp.ch_data[64*i +: 64] = 64'd0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus_fp.tx_wren === 1'b1) begin
            outq.push_back(bus_fp.tx_data);
            out_cyc.push_back(cyc);
        end
        if (bus_fp.drop_pulse === 1'b1) drop_cyc.push_back(cyc);
        if (bus_fp.timeout_pulse === 1'b1) to_cyc.push_back(cyc);
        if (bus_rr.tx_wren === 1'b1) begin
            rr_outq.push_back(bus_rr.tx_data);
            rr_cyc.push_back(cyc);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        srcq[1].push_back({1'b1, mkw(1, 0)});
        tick(4);
        n_checks++; if (bus_fp.ch_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus_fp.ch_ready); end
        n_checks++; if (bus_fp.tx_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", bus_fp.tx_wren); end
        n_checks++; if (bus_fp.tx_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus_fp.tx_data); end
        n_checks++; if (bus_fp.drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", bus_fp.drop_pulse); end
        n_checks++; if (bus_fp.timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus_fp.timeout_pulse); end
        n_checks++; if (bus_fp.stat_words !== 64'd0) begin n_fail++; $display("FAIL reset_stats: got %h want 0", bus_fp.stat_words); end
        rst = 1'b0;
        tick(4);
        n_checks++; if (outq.size() !== 1) begin n_fail++; $display("FAIL post_reset_count: got %0d want 1", outq.size()); end
        n_checks++; if (out_at(0) !== mkw(1, 0)) begin n_fail++; $display("FAIL post_reset_word: got %h want %h", out_at(0), mkw(1, 0)); end
        clear_obs();
    endtask

    task automatic test_fixed_priority();
        srcq[0].push_back({1'b1, mkw(0, 1)});
        srcq[2].push_back({1'b1, mkw(2, 1)});
        tick(6);
        n_checks++; if (outq.size() !== 2) begin n_fail++; $display("FAIL fp_count: got %0d want 2", outq.size()); end
        n_checks++; if (out_at(0) !== mkw(0, 1)) begin n_fail++; $display("FAIL fp_first: got %h want %h", out_at(0), mkw(0, 1)); end
        n_checks++; if (out_at(1) !== mkw(2, 1)) begin n_fail++; $display("FAIL fp_second: got %h want %h", out_at(1), mkw(2, 1)); end
        n_checks++; if (cyc_at(1) - cyc_at(0) !== 1) begin n_fail++; $display("FAIL fp_back_to_back: got gap %0d want 1", cyc_at(1) - cyc_at(0)); end
        clear_obs();
    endtask

    task automatic test_packet_lock();
        for (int i = 1; i <= 4; i++) srcq[1].push_back({(i == 4) ? 1'b1 : 1'b0, mkw(1, i)});
        tick(1);
        srcq[0].push_back({1'b1, mkw(0, 5)});
        tick(10);
        n_checks++; if (outq.size() !== 5) begin n_fail++; $display("FAIL lock_count: got %0d want 5", outq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_at(i) !== mkw(1, i + 1)) begin n_fail++; $display("FAIL lock_word%0d: got %h want %h", i, out_at(i), mkw(1, i + 1)); end
        end
        n_checks++; if (out_at(4) !== mkw(0, 5)) begin n_fail++; $display("FAIL lock_after: got %h want %h", out_at(4), mkw(0, 5)); end
        n_checks++; if (cyc_at(4) - cyc_at(0) !== 4) begin n_fail++; $display("FAIL lock_contiguous: got span %0d want 4", cyc_at(4) - cyc_at(0)); end
        clear_obs();
    endtask

    task automatic test_backpressure_magic();
        bus_fp.tx_almost_full = 1'b1;
        srcq[0].push_back({1'b1, 64'h0000_0000_0000_0377});
        srcq[0].push_back({1'b1, 64'h0000_0000_0000_0355});
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++; if (bus_fp.ch_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0000", i, bus_fp.ch_ready); end
            n_checks++; if (bus_fp.tx_wren !== 1'b0) begin n_fail++; $display("FAIL bp_wren%0d: got %b want 0", i, bus_fp.tx_wren); end
        end
        bus_fp.tx_almost_full = 1'b0;
        tick(6);
        n_checks++; if (outq.size() !== 1) begin n_fail++; $display("FAIL magic_count: got %0d want 1", outq.size()); end
        n_checks++; if (out_at(0) !== 64'h0000_0000_0000_0377) begin n_fail++; $display("FAIL magic_word: got %h want 0377", out_at(0)); end
        n_checks++; if (drop_cyc.size() !== 1) begin n_fail++; $display("FAIL drop_count: got %0d want 1", drop_cyc.size()); end
        n_checks++; if (drop_at(0) - cyc_at(0) !== 1) begin n_fail++; $display("FAIL drop_timing: got offset %0d want 1", drop_at(0) - cyc_at(0)); end
        clear_obs();
    endtask

    task automatic test_watchdog();
        srcq[2].push_back({1'b0, mkw(2, 0)});
        tick(4);
        srcq[3].push_back({1'b1, mkw(3, 0)});
        tick(16);
        n_checks++; if (outq.size() !== 2) begin n_fail++; $display("FAIL wd_count: got %0d want 2", outq.size()); end
        n_checks++; if (out_at(0) !== mkw(2, 0)) begin n_fail++; $display("FAIL wd_first: got %h want %h", out_at(0), mkw(2, 0)); end
        n_checks++; if (out_at(1) !== mkw(3, 0)) begin n_fail++; $display("FAIL wd_next: got %h want %h", out_at(1), mkw(3, 0)); end
        n_checks++; if (to_cyc.size() !== 1) begin n_fail++; $display("FAIL wd_pulses: got %0d want 1", to_cyc.size()); end
        n_checks++; if (to_at(0) - cyc_at(0) !== 8) begin n_fail++; $display("FAIL wd_timing: got %0d want 8", to_at(0) - cyc_at(0)); end
        n_checks++; if (cyc_at(1) - cyc_at(0) !== 9) begin n_fail++; $display("FAIL wd_regrant: got %0d want 9", cyc_at(1) - cyc_at(0)); end
        clear_obs();
    endtask

    task automatic test_round_robin();
        bus_rr.ch_data  = {mkw(3, 9), mkw(2, 9), mkw(1, 9), mkw(0, 9)};
        bus_rr.ch_last  = 4'b1111;
        bus_rr.ch_valid = 4'b1111;
        tick(1);
        n_checks++; if (bus_rr.ch_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_ready: got %b want 0010", bus_rr.ch_ready); end
        tick(5);
        bus_rr.ch_valid = 4'b0000;
        tick(3);
        n_checks++; if (rr_outq.size() !== 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", rr_outq.size()); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (rr_at(i) !== mkw(i % 4, 9)) begin n_fail++; $display("FAIL rr_order%0d: got %h want %h", i, rr_at(i), mkw(i % 4, 9)); end
        end
        n_checks++; if (rr_cyc_at(5) - rr_cyc_at(0) !== 5) begin n_fail++; $display("FAIL rr_rate: got span %0d want 5", rr_cyc_at(5) - rr_cyc_at(0)); end
    endtask

    task automatic test_stats();
`ifdef PCILEECH_TX_ARB_STATS_EN
        int n = 0;
        for (int i = 0; i < 70000; i++) srcq[0].push_back({1'b1, mkw(0, i)});
        while (srcq[0].size() > 0 && n < 70100) begin
            tick(1);
            n++;
        end
        n_checks++; if (srcq[0].size() !== 0) begin n_fail++; $display("FAIL stats_drain: got %0d left want 0", srcq[0].size()); end
        tick(2);
        n_checks++; if (bus_fp.stat_words[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate: got %h want ffff", bus_fp.stat_words[15:0]); end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_checks++; if (bus_fp.stat_words[15:0] !== 16'h0000) begin n_fail++; $display("FAIL stats_reset: got %h want 0000", bus_fp.stat_words[15:0]); end
`else
        n_checks++; if (bus_fp.stat_words !== 64'd0) begin n_fail++; $display("FAIL stats_tied: got %h want 0", bus_fp.stat_words); end
`endif
        clear_obs();
    endtask

    initial begin
        rst                   = 1'b1;
        bus_fp.tx_almost_full = 1'b0;
        bus_rr.tx_almost_full = 1'b0;
        bus_rr.ch_valid       = 4'b0000;
        bus_rr.ch_last        = 4'b0000;
        bus_rr.ch_data        = 256'd0;
        test_reset();
        test_fixed_priority();
        test_packet_lock();
        test_backpressure_magic();
        test_watchdog();
        test_round_robin();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
